// File: rtl/multi_cycle_mips.sv
// multi_cycle_mips: FETCH/EXEC/MEM sequenced MIPS subset core with ready-handshaked memories,
// halt on illegal instruction and a retired-instruction counter.
module multi_cycle_mips #(
  parameter int          DADDR_W  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        IR_addr,
  output logic               ir_req,
  input  logic [31:0]        IR,
  input  logic               IR_ready,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DADDR_W-1:0] A,
  output logic [31:0]        Data2Mem,
  input  logic [31:0]        ReadDataMem,
  input  logic               mem_ready,
  output logic               halted,
  output logic [CNT_W-1:0]   instret
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, ir_q, d_q;
  logic [DADDR_W-1:0] a_q;
  logic lw_q;
  logic [31:0] rf [32];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt, wa;
  logic [31:0] rs_v, rt_v, imm_s, pc4, res, npc, addr;
  logic we, legal, mem_op;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign rs_v  = rf[rs];
  assign rt_v  = rf[rt];
  assign imm_s = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc4   = pc + 32'd4;
  assign addr  = rs_v + imm_s;
  always_comb begin
    res = '0;
    wa = rd;
    we = 1'b0;
    npc = pc4;
    legal = 1'b1;
    mem_op = 1'b0;
    case (op)
      6'h00: begin
        we = funct != 6'h08;
        case (funct)
          6'h20: res = rs_v + rt_v;
          6'h22: res = rs_v - rt_v;
          6'h24: res = rs_v & rt_v;
          6'h25: res = rs_v | rt_v;
          6'h2A: res = {31'd0, $signed(rs_v) < $signed(rt_v)};
          6'h00: res = rt_v << shamt;
          6'h02: res = rt_v >> shamt;
          6'h08: npc = {rs_v[31:2], 2'b00};
          default: begin
            legal = 1'b0;
            we = 1'b0;
          end
        endcase
      end
      6'h08: begin
        we = 1'b1;
        wa = rt;
        res = rs_v + imm_s;
      end
      6'h0C: begin
        we = 1'b1;
        wa = rt;
        res = rs_v & {16'd0, ir_q[15:0]};
      end
      6'h0D: begin
        we = 1'b1;
        wa = rt;
        res = rs_v | {16'd0, ir_q[15:0]};
      end
      6'h23, 6'h2B: mem_op = 1'b1;
      6'h04: npc = rs_v == rt_v ? pc4 + (imm_s << 2) : pc4;
      6'h05: npc = rs_v != rt_v ? pc4 + (imm_s << 2) : pc4;
      6'h02: npc = {pc4[31:28], ir_q[25:0], 2'b00};
      6'h03: begin
        npc = {pc4[31:28], ir_q[25:0], 2'b00};
        we = 1'b1;
        wa = 5'd31;
        res = pc4;
      end
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? FETCH : state_n;
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = IR_ready ? EXEC : FETCH;
      EXEC:    state_n = !legal ? HALT : mem_op ? MEM : FETCH;
      MEM:     state_n = mem_ready ? FETCH : MEM;
      default: state_n = HALT;
    endcase
  end
  always_comb begin
    ir_req   = !rst && state == FETCH;
    IR_addr  = rst ? RESET_PC : pc;
    CEN      = rst || state != MEM;
    OEN      = CEN || !lw_q;
    WEN      = CEN || lw_q;
    A        = rst ? '0 : a_q;
    Data2Mem = rst ? '0 : d_q;
    halted   = !rst && state == HALT;
  end
  // ir_q stays valid through MEM so rt still names the load destination
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      d_q <= '0;
      lw_q <= 1'b0;
      instret <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (state == FETCH && IR_ready) ir_q <= IR;
      if (state == EXEC && legal) begin
        if (mem_op) begin
          a_q <= DADDR_W'(addr >> 2);
          d_q <= rt_v;
          lw_q <= !op[3];
        end else begin
          pc <= npc;
          instret <= instret + CNT_W'(1);
          if (we && wa != 5'd0) rf[wa] <= res;
        end
      end
      if (state == MEM && mem_ready) begin
        pc <= pc4;
        instret <= instret + CNT_W'(1);
        if (lw_q && rt != 5'd0) rf[rt] <= ReadDataMem;
      end
    end
  end
endmodule
